// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared processor constants and hazard-FSM state encoding
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR_HOLD = 2'd2} state_e;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam int WAIT_W = 8;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use comparator between the ID/EX load and the ID sources
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu
);
  assign lu = idex_memread && idex_rt != ZERO_REG && (idex_rt == id_rs || idex_rt == id_rt);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for memory waits, taken branches and load-use hazards
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_memop,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state_o
);
  state_e state, state_nx;
  logic [WAIT_W-1:0] wcnt;
  logic lu, mem_stall, hold, run, flush_br, stall_lu;
  hazard_detect u_hazard_detect (
    .idex_memread(idex_memread),
    .idex_rt(idex_rt),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .lu(lu)
  );
  assign mem_stall = exmem_memop && !mem_ready;
  assign state_o = state;
  // wcnt is zero on every entry to MEM_WAIT because it only counts while already there
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt <= '0;
      mem_err <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      wcnt <= (state == MEM_WAIT) ? wcnt + WAIT_W'(1) : '0;
      if (state_nx == ERR_HOLD) mem_err <= 1'b1;
      if (!pc_en) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
  always_comb begin
    state_nx = state;
    if (state == RUN && mem_stall) state_nx = MEM_WAIT;
    else if (state == MEM_WAIT)
      state_nx = mem_ready ? RUN :
                 ({1'b0, wcnt} + 9'd1 >= 9'(MAX_WAIT)) ? ERR_HOLD : MEM_WAIT;
  end
  always_comb begin
    hold = !rst && (state == ERR_HOLD || (state == MEM_WAIT && !mem_ready) || (state == RUN && mem_stall));
    run = !rst && state == RUN && !mem_stall;
    flush_br = run && branch_taken;
    stall_lu = run && !branch_taken && lu;
    pc_en = !hold && !stall_lu;
    ifid_en = !hold && !stall_lu;
    idex_en = !hold;
    exmem_en = !hold;
    memwb_en = !hold;
    ifid_flush = flush_br;
    idex_flush = flush_br || stall_lu;
    memwb_bubble = hold && state != ERR_HOLD;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks against a behavioural hazard model
module tb_pipeline_hazard_ctrl;
  localparam int MW = 4;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic idex_memread = 1'b0, exmem_memop = 1'b0, mem_ready = 1'b1, branch_taken = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [CW-1:0] stall_cycles;
  logic [1:0] state_o;
  logic [7:0] outs;
  int total = 0, bad = 0;
  int m_st = 0, m_wait = 0, m_stalls = 0;
  bit m_err = 0;

  pipeline_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .idex_memread(idex_memread),
    .idex_rt(idex_rt), .exmem_memop(exmem_memop), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cycles(stall_cycles), .state_o(state_o)
  );

  always #5 clk = ~clk;
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble};

  // {pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_flush, memwb_bubble}
  function automatic logic [7:0] exp_outs();
    bit lu = idex_memread && idex_rt != 0 && (idex_rt == id_rs || idex_rt == id_rt);
    if (rst) return 8'b11111_000;
    if (m_st == 2) return 8'b00000_000;
    if (m_st == 1) return mem_ready ? 8'b11111_000 : 8'b00000_001;
    if (exmem_memop && !mem_ready) return 8'b00000_001;
    if (branch_taken) return 8'b11111_110;
    if (lu) return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  task automatic tick();
    logic [7:0] e = exp_outs();
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_wait = 0; m_err = 0; m_stalls = 0;
    end else begin
      if (!e[7]) m_stalls = (m_stalls + 1) % (1 << CW);
      if (m_st == 0 && exmem_memop && !mem_ready) begin
        m_st = 1; m_wait = 0;
      end else if (m_st == 1) begin
        m_wait++;
        if (mem_ready) m_st = 0;
        else if (m_wait >= MW) begin m_st = 2; m_err = 1; end
      end
    end
    #1;
  endtask

  task automatic quiet();
    id_rs = 0; id_rt = 0; idex_rt = 0; idex_memread = 0; exmem_memop = 0; mem_ready = 1; branch_taken = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      exmem_memop = 1'($urandom); mem_ready = 1'($urandom); branch_taken = 1'($urandom);
      idex_memread = 1; idex_rt = 5'd3; id_rs = 5'd3;
      #3;
      total++;
      if (outs !== 8'b11111_000) begin bad++; $display("FAIL reset_outs: got %b want 11111000", outs); end
      tick();
    end
    rst = 0; quiet(); #3;
    total++;
    if ({state_o, mem_err, stall_cycles} !== {2'd0, 1'b0, 8'd0}) begin
      bad++; $display("FAIL reset_state: state=%0d err=%b stalls=%0d want 0 0 0", state_o, mem_err, stall_cycles);
    end
  endtask

  task automatic test_load_use();
    logic [CW-1:0] s0 = stall_cycles;
    idex_memread = 1; idex_rt = 5; id_rs = 5; id_rt = 9; #3;
    total++;
    if (outs !== 8'b00111_010) begin bad++; $display("FAIL load_use_outs: got %b want 00111010", outs); end
    tick(); quiet(); #3;
    total++;
    if (stall_cycles !== s0 + 8'd1) begin bad++; $display("FAIL load_use_count: got %0d want %0d", stall_cycles, s0 + 8'd1); end
    total++;
    if (outs !== 8'b11111_000) begin bad++; $display("FAIL load_use_release: got %b want 11111000", outs); end
    idex_memread = 1; idex_rt = 7; id_rs = 1; id_rt = 7; #1;
    total++;
    if (outs !== 8'b00111_010) begin bad++; $display("FAIL load_use_rt: got %b want 00111010", outs); end
    tick(); quiet();
  endtask

  task automatic test_zero_reg();
    idex_memread = 1; idex_rt = 0; id_rs = 0; id_rt = 0; #3;
    total++;
    if (outs !== 8'b11111_000) begin bad++; $display("FAIL zero_reg: got %b want 11111000", outs); end
    tick(); quiet();
  endtask

  task automatic test_mem_wait();
    logic [CW-1:0] s0 = stall_cycles;
    exmem_memop = 1; mem_ready = 0; branch_taken = 1; idex_memread = 1; idex_rt = 4; id_rs = 4;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      #3;
      total++;
      if (outs !== (i == 3 ? 8'b11111_000 : 8'b00000_001) || state_o !== (i == 0 ? 2'd0 : 2'd1)) begin
        bad++; $display("FAIL mem_wait_c%0d: outs=%b state=%0d", i, outs, state_o);
      end
      tick();
    end
    quiet(); #3;
    total++;
    if (state_o !== 2'd0 || stall_cycles !== s0 + 8'd3) begin
      bad++; $display("FAIL mem_wait_end: state=%0d stalls=%0d want 0 %0d", state_o, stall_cycles, s0 + 8'd3);
    end
  endtask

  task automatic test_branch_lu();
    idex_memread = 1; idex_rt = 12; id_rt = 12; branch_taken = 1; #3;
    total++;
    if (outs !== 8'b11111_110) begin bad++; $display("FAIL branch_lu: got %b want 11111110", outs); end
    tick(); quiet();
  endtask

  task automatic test_timeout();
    exmem_memop = 1; mem_ready = 0;
    for (int i = 0; i <= MW; i++) tick();
    #1;
    total++;
    if (state_o !== 2'd2 || mem_err !== 1'b1) begin
      bad++; $display("FAIL timeout_enter: state=%0d err=%b want 2 1", state_o, mem_err);
    end
    mem_ready = 1; branch_taken = 1; tick(); #1;
    total++;
    if (state_o !== 2'd2 || mem_err !== 1'b1 || outs[7:3] !== 5'b0) begin
      bad++; $display("FAIL timeout_hold: state=%0d err=%b outs=%b", state_o, mem_err, outs);
    end
    quiet(); rst = 1; #1;
    total++;
    if (outs !== 8'b11111_000) begin bad++; $display("FAIL timeout_rst_outs: got %b want 11111000", outs); end
    tick(); rst = 0; #1;
    total++;
    if (state_o !== 2'd0 || mem_err !== 1'b0) begin
      bad++; $display("FAIL timeout_clear: state=%0d err=%b want 0 0", state_o, mem_err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    idex_memread = 1; idex_rt = 2; id_rs = 2;
    for (int i = 0; i < (1 << CW) - 1; i++) tick();
    #1;
    total++;
    if (stall_cycles !== 8'd255) begin bad++; $display("FAIL wrap_top: got %0d want 255", stall_cycles); end
    tick(); #1;
    total++;
    if (stall_cycles !== 8'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", stall_cycles); end
    quiet();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); idex_rt = 5'($urandom_range(0, 3));
      idex_memread = 1'($urandom); branch_taken = ($urandom_range(0, 3) == 0);
      exmem_memop = ($urandom_range(0, 2) == 0); mem_ready = 1'($urandom);
      #3;
      total++;
      if ({outs, state_o, mem_err, stall_cycles} !== {exp_outs(), 2'(m_st), m_err, 8'(m_stalls)}) begin
        bad++;
        $display("FAIL random_%0d: outs=%b st=%0d err=%b stalls=%0d want %b %0d %b %0d",
                 i, outs, state_o, mem_err, stall_cycles, exp_outs(), m_st, m_err, m_stalls);
      end
      tick();
    end
    rst = 0; quiet();
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mem_wait();
    test_branch_lu();
    test_timeout();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
